// File: rtl/mac_pe_pkg.sv
// rtl/mac_pe_pkg.sv - shared types and saturating add helper for the output-stationary MAC PE
package mac_pe_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } pe_state_e;

  localparam int SAT_MAXW = 64;

  typedef struct packed {
    logic [SAT_MAXW-1:0] sum;
    logic                clamped;
  } sat_res_t;

  // Adds prod to acc within 'width' bits, clamping to the signed or unsigned range on overflow.
  function automatic sat_res_t sat_add(input logic [SAT_MAXW-1:0] acc,
                                       input logic [SAT_MAXW-1:0] prod,
                                       input logic                is_signed,
                                       input int                  width);
    logic [SAT_MAXW:0]   raw;
    logic [SAT_MAXW-1:0] mask;
    logic [SAT_MAXW-1:0] sbit;
    logic                sa;
    logic                sp;
    logic                ss;
    sat_res_t            res;
    mask = (width >= SAT_MAXW) ? '1 : ((SAT_MAXW'(1) << width) - SAT_MAXW'(1));
    sbit = SAT_MAXW'(1) << (width - 1);
    raw  = {1'b0, acc & mask} + {1'b0, prod & mask};
    sa   = |(acc & sbit);
    sp   = |(prod & sbit);
    ss   = |(raw[SAT_MAXW-1:0] & sbit);
    res.sum     = raw[SAT_MAXW-1:0] & mask;
    res.clamped = 1'b0;
    if (is_signed) begin
      // Same-sign operands producing an opposite-sign sum is a signed overflow.
      if ((sa == sp) && (ss != sa)) begin
        res.clamped = 1'b1;
        res.sum     = sa ? sbit : (mask & ~sbit);
      end
    end else if (|((raw >> width) & (SAT_MAXW+1)'(1))) begin
      res.clamped = 1'b1;
      res.sum     = mask;
    end
    return res;
  endfunction

endpackage

// File: rtl/mac_pe_acc.sv
// rtl/mac_pe_acc.sv - product, extension, add and accumulator register (MAC_PE_SAT_EN selects saturation)
module mac_pe_acc
  import mac_pe_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  en,
  input  logic                  is_signed,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0]  acc,
  output logic                  sat
);

  logic signed [2*DATA_WIDTH-1:0] prod_s;
  logic        [2*DATA_WIDTH-1:0] prod_u;
  logic signed [ACC_WIDTH-1:0]    prod_sx;
  logic        [ACC_WIDTH-1:0]    prod_ux;
  logic        [ACC_WIDTH-1:0]    prod_ext;
  logic        [ACC_WIDTH-1:0]    acc_q;
  logic        [ACC_WIDTH-1:0]    acc_nxt;

  assign prod_s   = (2*DATA_WIDTH)'($signed(a)) * (2*DATA_WIDTH)'($signed(b));
  assign prod_u   = (2*DATA_WIDTH)'(a) * (2*DATA_WIDTH)'(b);
  assign prod_sx  = ACC_WIDTH'(prod_s);
  assign prod_ux  = ACC_WIDTH'(prod_u);
  assign prod_ext = is_signed ? prod_sx : prod_ux;

`ifdef MAC_PE_SAT_EN
  sat_res_t sat_res;
  logic     sat_q;
  logic     sat_hi_unused;

  assign sat_res       = sat_add(SAT_MAXW'(acc_q), SAT_MAXW'(prod_ext), is_signed, ACC_WIDTH);
  assign acc_nxt       = sat_res.sum[ACC_WIDTH-1:0];
  assign sat_hi_unused = ^sat_res.sum[SAT_MAXW-1:ACC_WIDTH];

  // Sticky clamp flag for the current tile, cleared when a new tile starts.
  always_ff @(posedge clk) begin
    if (!rst_n)                        sat_q <= 1'b0;
    else if (clr)                      sat_q <= 1'b0;
    else if (en && sat_res.clamped)    sat_q <= 1'b1;
  end

  assign sat = sat_q;
`else
  assign acc_nxt = acc_q + prod_ext;
  assign sat     = 1'b0;
`endif

  // Accumulator register: cleared at tile start, updated on each accepted operand pair.
  always_ff @(posedge clk) begin
    if (!rst_n)   acc_q <= '0;
    else if (clr) acc_q <= '0;
    else if (en)  acc_q <= acc_nxt;
  end

  assign acc = acc_q;

endmodule

// File: rtl/mac_pe_os.sv
// rtl/mac_pe_os.sv - output-stationary systolic MAC PE with drain chain (optional MAC_PE_SAT_EN)
module mac_pe_os
  import mac_pe_pkg::*;
#(
  parameter int  DATA_WIDTH = 8,
  parameter int  ACC_WIDTH  = 32,
  parameter int  K_MAX      = 256,
  localparam int KW         = $clog2(K_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [KW-1:0]         k_len,
  input  logic                  signed_en,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic                  a_vld_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic                  b_vld_in,
  output logic [DATA_WIDTH-1:0] a_out,
  output logic                  a_vld_out,
  output logic [DATA_WIDTH-1:0] b_out,
  output logic                  b_vld_out,
  input  logic                  drain,
  input  logic [ACC_WIDTH-1:0]  ps_in,
  input  logic                  ps_vld_in,
  output logic [ACC_WIDTH-1:0]  ps_out,
  output logic                  ps_vld_out,
  output logic                  done,
  output logic                  busy,
  output logic                  sat_flag
);

  pe_state_e            state;
  pe_state_e            next_state;
  logic [KW-1:0]        cnt;
  logic [KW-1:0]        k_lat;
  logic                 sgn_lat;
  logic                 pending;
  logic                 acc_clr;
  logic                 acc_en;
  logic                 unload;
  logic [ACC_WIDTH-1:0] acc;

  // Systolic operand forwarding, independent of the tile FSM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_out     <= '0;
      a_vld_out <= 1'b0;
      b_out     <= '0;
      b_vld_out <= 1'b0;
    end else begin
      a_out     <= a_in;
      a_vld_out <= a_vld_in;
      b_out     <= b_in;
      b_vld_out <= b_vld_in;
    end
  end

  // Tile state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state and datapath strobes; start overrides any in-flight tile.
  always_comb begin
    next_state = state;
    acc_clr    = 1'b0;
    acc_en     = 1'b0;
    unload     = 1'b0;
    if (start) begin
      acc_clr    = 1'b1;
      next_state = (k_len == '0) ? HOLD : ACCUM;
    end else begin
      case (state)
        ACCUM: begin
          if (a_vld_in && b_vld_in) begin
            acc_en = 1'b1;
            if (cnt + KW'(1) == k_lat) next_state = HOLD;
          end
        end
        HOLD: begin
          // Chain traffic from upstream owns the output slot; unload waits for a free cycle.
          if ((drain || pending) && !ps_vld_in) begin
            unload     = 1'b1;
            next_state = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // Tile bookkeeping: product count, latched tile config and deferred drain request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      k_lat   <= '0;
      sgn_lat <= 1'b0;
      pending <= 1'b0;
    end else if (start) begin
      cnt     <= '0;
      k_lat   <= k_len;
      sgn_lat <= signed_en;
      pending <= 1'b0;
    end else begin
      if (acc_en) cnt <= cnt + KW'(1);
      if (unload)                                    pending <= 1'b0;
      else if ((state == HOLD) && drain && ps_vld_in) pending <= 1'b1;
    end
  end

  // Drain chain output: forward upstream first, else emit own result once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ps_out     <= '0;
      ps_vld_out <= 1'b0;
    end else if (ps_vld_in) begin
      ps_out     <= ps_in;
      ps_vld_out <= 1'b1;
    end else if (unload) begin
      ps_out     <= acc;
      ps_vld_out <= 1'b1;
    end else begin
      ps_vld_out <= 1'b0;
    end
  end

  mac_pe_acc #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (acc_clr),
    .en       (acc_en),
    .is_signed(sgn_lat),
    .a        (a_in),
    .b        (b_in),
    .acc      (acc),
    .sat      (sat_flag)
  );

  assign done = (state == HOLD);
  assign busy = (state == ACCUM);

endmodule

// File: tb/tb_mac_pe_os.sv
// tb/tb_mac_pe_os.sv - self-checking bench for mac_pe_os (honours MAC_PE_SAT_EN)
module tb_mac_pe_os;

  localparam int DW = 8;
  localparam int AW = 16;
  localparam int KM = 256;
  localparam int KW = $clog2(KM + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [KW-1:0] k_len;
  logic          signed_en;
  logic [DW-1:0] a_in, b_in, a_out, b_out;
  logic          a_vld_in, b_vld_in, a_vld_out, b_vld_out;
  logic          drain;
  logic [AW-1:0] ps_in, ps_out;
  logic          ps_vld_in, ps_vld_out;
  logic          done, busy, sat_flag;

  mac_pe_os #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .K_MAX(KM)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .signed_en(signed_en),
    .a_in(a_in), .a_vld_in(a_vld_in), .b_in(b_in), .b_vld_in(b_vld_in),
    .a_out(a_out), .a_vld_out(a_vld_out), .b_out(b_out), .b_vld_out(b_vld_out),
    .drain(drain), .ps_in(ps_in), .ps_vld_in(ps_vld_in),
    .ps_out(ps_out), .ps_vld_out(ps_vld_out),
    .done(done), .busy(busy), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  int     vectors = 0;
  int     miscompares = 0;
  longint m_acc;
  bit     m_sat;
  bit     m_sgn;
  int     busy_samples;
  logic [DW-1:0] dq_a[$];
  logic [DW-1:0] dq_b[$];
  bit            dq_v[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference accumulation on mathematical integers, then wrap or clamp to AW bits.
  task automatic model_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint p, s, lo, hi;
    p  = m_sgn ? longint'($signed(a)) * longint'($signed(b)) : longint'(a) * longint'(b);
    s  = m_acc + p;
    lo = m_sgn ? -(longint'(1) <<< (AW - 1)) : 0;
    hi = m_sgn ? (longint'(1) <<< (AW - 1)) - 1 : (longint'(1) <<< AW) - 1;
`ifdef MAC_PE_SAT_EN
    if (s > hi) begin s = hi; m_sat = 1'b1; end
    if (s < lo) begin s = lo; m_sat = 1'b1; end
`else
    s = s & ((longint'(1) <<< AW) - 1);
    if (m_sgn && s > hi) s = s - (longint'(1) <<< AW);
`endif
    m_acc = s;
  endtask

  function automatic logic [AW-1:0] model_bits();
    logic [63:0] t;
    t = 64'(m_acc);
    return t[AW-1:0];
  endfunction

  // Starts a tile, feeds k accepted pairs (directed queues first, else random), ends in HOLD.
  task automatic run_tile(input int k, input bit sgn, input bit gaps);
    int  n, guard;
    bit  both;
    start = 1'b1; k_len = KW'(k); signed_en = sgn;
    m_acc = 0; m_sat = 1'b0; m_sgn = sgn;
    step();
    start = 1'b0;
    check("busy_after_start", busy, 64'(k != 0));
    check("done_after_start", done, 64'(k == 0));
    check("sat_clear_on_start", sat_flag, 0);
    busy_samples = busy ? 1 : 0;
    n = 0; guard = 0;
    while (n < k && guard < 4000) begin
      if (dq_v.size() > 0) both = dq_v.pop_front();
      else if (gaps)      both = ($urandom_range(0, 2) != 0);
      else                both = 1'b1;
      a_in = (both && dq_a.size() > 0) ? dq_a.pop_front() : DW'($urandom);
      b_in = (both && dq_b.size() > 0) ? dq_b.pop_front() : DW'($urandom);
      if (both) begin
        a_vld_in = 1'b1; b_vld_in = 1'b1;
        model_add(a_in, b_in);
        n++;
      end else begin
        a_vld_in = 1'($urandom_range(0, 1));
        b_vld_in = 1'b0;
        if ($urandom_range(0, 1) == 1) begin b_vld_in = a_vld_in; a_vld_in = 1'b0; end
      end
      step();
      guard++;
      if (busy) busy_samples++;
      if (n < k) check("busy_in_accum", busy, 1);
    end
    a_vld_in = 1'b0; b_vld_in = 1'b0;
    check("done_at_end", done, 1);
    check("busy_at_end", busy, 0);
    check("sat_flag_tile", sat_flag, 64'(m_sat));
  endtask

  task automatic drain_check(input string tag, input logic [AW-1:0] exp);
    drain = 1'b1;
    step();
    drain = 1'b0;
    check({tag, "_vld"}, ps_vld_out, 1);
    check(tag, ps_out, 64'(exp));
    check({tag, "_idle"}, done, 0);
    step();
    check({tag, "_vld_drop"}, ps_vld_out, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; k_len = '0; signed_en = 1'b0;
    a_in = '0; b_in = '0; a_vld_in = 1'b0; b_vld_in = 1'b0;
    drain = 1'b0; ps_in = '0; ps_vld_in = 1'b0;
    step(); step();
    check("rst_ps_out", ps_out, 0);
    check("rst_ps_vld", ps_vld_out, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_a_out", a_out, 0);
    check("rst_sat", sat_flag, 0);
    rst_n = 1'b1;
    step();

    // Forwarding is a plain one-cycle delay.
    for (int i = 0; i < 10; i++) begin
      logic [DW-1:0] pa, pb;
      logic          pva, pvb;
      pa = DW'($urandom); pb = DW'($urandom);
      pva = 1'($urandom); pvb = 1'($urandom);
      a_in = pa; b_in = pb; a_vld_in = pva; b_vld_in = pvb;
      step();
      check("fwd_a", {a_vld_out, a_out}, {pva, pa});
      check("fwd_b", {b_vld_out, b_out}, {pvb, pb});
    end
    a_vld_in = 1'b0; b_vld_in = 1'b0;

    // Unsigned k=4, A=1..4, B=2.
    for (int i = 1; i <= 4; i++) begin dq_a.push_back(DW'(i)); dq_b.push_back(8'd2); end
    run_tile(4, 1'b0, 1'b0);
    drain_check("t1_result", 16'd20);

    // Signed k=2: -3*5 + -1*-1 = -14.
    dq_a = '{8'hFD, 8'hFF}; dq_b = '{8'h05, 8'hFF};
    run_tile(2, 1'b1, 1'b0);
    drain_check("t2_signed", 16'hFFF2);
    dq_a = '{8'hFD, 8'hFF}; dq_b = '{8'h05, 8'hFF};
    run_tile(2, 1'b0, 1'b0);
    drain_check("t2_unsigned", model_bits());

    // k=3 with valid pattern 1,0,0,1,1 keeps busy for 5 sampled cycles.
    dq_v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    run_tile(3, 1'b0, 1'b0);
    check("t3_busy_cycles", busy_samples, 5);
    drain_check("t3_result", model_bits());

    // k=0 goes straight to HOLD with a zero result.
    run_tile(0, 1'b1, 1'b0);
    drain_check("t4_zero", 16'd0);

    // Drain ignored outside HOLD.
    drain = 1'b1;
    step();
    drain = 1'b0;
    check("drain_idle_ignored", ps_vld_out, 0);

    // Drain while the chain is busy: forwarded words first, own result right after.
    run_tile(3, 1'b1, 1'b1);
    ps_vld_in = 1'b1; ps_in = 16'd7; drain = 1'b1;
    step();
    drain = 1'b0;
    check("t5_fwd7", {ps_vld_out, ps_out}, {1'b1, 16'd7});
    check("t5_hold7", done, 1);
    ps_in = 16'd8;
    step();
    check("t5_fwd8", {ps_vld_out, ps_out}, {1'b1, 16'd8});
    ps_in = 16'd9;
    step();
    check("t5_fwd9", {ps_vld_out, ps_out}, {1'b1, 16'd9});
    check("t5_hold9", done, 1);
    ps_vld_in = 1'b0;
    step();
    check("t5_own", {ps_vld_out, ps_out}, {1'b1, model_bits()});
    check("t5_idle", done, 0);
    step();
    check("t5_vld_drop", ps_vld_out, 0);

    // Restart mid-tile abandons the partial sum.
    start = 1'b1; k_len = KW'(5); signed_en = 1'b0;
    step();
    start = 1'b0;
    a_in = 8'hFF; b_in = 8'hFF; a_vld_in = 1'b1; b_vld_in = 1'b1;
    step(); step();
    run_tile(4, 1'b1, 1'b1);
    drain_check("restart_result", model_bits());

    // Overflow: two products of 16384 exceed the signed 16-bit range.
    dq_a = '{8'h80, 8'h80}; dq_b = '{8'h80, 8'h80};
    run_tile(2, 1'b1, 1'b0);
`ifdef MAC_PE_SAT_EN
    check("t6_sat_flag", sat_flag, 1);
    drain_check("t6_clamp", 16'h7FFF);
`else
    check("t6_sat_flag", sat_flag, 0);
    drain_check("t6_wrap", 16'h8000);
`endif
    dq_a = '{8'hFF, 8'hFF}; dq_b = '{8'hFF, 8'hFF};
    run_tile(2, 1'b0, 1'b0);
    drain_check("t6_unsigned_ovf", model_bits());

    // Random tiles, including the K_MAX boundary.
    for (int t = 0; t < 8; t++) begin
      run_tile($urandom_range(0, 12), 1'($urandom), 1'b1);
      drain_check("rand_tile", model_bits());
    end
    run_tile(KM, 1'b1, 1'b0);
    drain_check("kmax_signed", model_bits());
    run_tile(KM, 1'b0, 1'b1);
    drain_check("kmax_unsigned", model_bits());

    // Reset in the middle of accumulation clears everything at once.
    ps_vld_in = 1'b1; ps_in = 16'h1234;
    step();
    ps_vld_in = 1'b0;
    start = 1'b1; k_len = KW'(10); signed_en = 1'b1;
    step();
    start = 1'b0;
    a_in = 8'h55; b_in = 8'h33; a_vld_in = 1'b1; b_vld_in = 1'b1;
    step(); step();
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    step();
    check("mid_rst_outputs",
          {a_out, a_vld_out, b_out, b_vld_out, ps_out, ps_vld_out, done, busy, sat_flag}, 0);
    rst_n = 1'b1; a_vld_in = 1'b0; b_vld_in = 1'b0;
    step();
    check("post_rst_idle", {done, busy, ps_vld_out}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
